uart_cmd_responder: RTL

//  Far end of the LED-select UART link: consumes bytes from a byte-level UART receiver,

---
 rtl/uart_cmd_pkg.sv | 32 +++
 rtl/uart_tx_byte.sv | 93 +++++++++
 rtl/uart_cmd_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
//   Shared constants and types for the LED-select UART command responder:
//   frame header default, terminator, reply byte constants, accepted select
//   range and the parser state enum.
//   Optional feature macro used by the design files: UART_RESP_PARITY_EN.
package uart_cmd_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'h55;
  localparam logic [7:0] TERM        = 8'h0D;

  // Reply bytes: "OK" and "ER"
  localparam logic [7:0] OK_B0 = 8'h4F;
  localparam logic [7:0] OK_B1 = 8'h4B;
  localparam logic [7:0] ER_B0 = 8'h45;
  localparam logic [7:0] ER_B1 = 8'h52;

  // ASCII '0'..'7' are the only select bytes that change the LEDs
  localparam logic [7:0] SEL_MIN = 8'h30;
  localparam logic [7:0] SEL_MAX = 8'h37;

  typedef enum logic [1:0] {
    S_HDR   = 2'd0,
    S_SEL   = 2'd1,
    S_END   = 2'd2,
    S_REPLY = 2'd3
  } state_e;

  function automatic logic sel_in_range(input logic [7:0] sel);
    return (sel >= SEL_MIN) && (sel <= SEL_MAX);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte
//   Serializes one byte per load pulse: start(0), 8 data bits LSB first,
//   optional even parity, stop(1). Each bit lasts CLKS_PER_BIT cycles.
//   A load takes effect at once (start bit on tx_o the next cycle), and a
//   load in the same cycle as done_o chains the next byte with no idle gap.
//   Macro: UART_RESP_PARITY_EN adds an even-parity bit (11 bits per byte).
// Ports
//   clk_i    in   1  clock
//   srst_i   in   1  synchronous active-high reset
//   load_i   in   1  start sending data_i
//   data_i   in   8  byte to send
//   tx_o     out  1  serial line, idle high
//   done_o   out  1  high during the last cycle of the stop bit
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       done_o
);

`ifdef UART_RESP_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [NBITS-1:0] frame_q, frame_d, frame_load;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [3:0]       bit_q, bit_d;
  logic             active_q, active_d;
  logic             baud_last, bit_last;

  // Whole frame is loaded into a shift register; bit 0 drives the line.
  always_comb begin
`ifdef UART_RESP_PARITY_EN
    frame_load = {1'b1, ^data_i, data_i, 1'b0};
`else
    frame_load = {1'b1, data_i, 1'b0};
`endif
  end

  assign baud_last = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
  assign bit_last  = (bit_q == 4'(NBITS - 1));

  always_comb begin
    frame_d  = frame_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    active_d = active_q;
    if (load_i) begin
      frame_d  = frame_load;
      baud_d   = '0;
      bit_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (baud_last) begin
        baud_d  = '0;
        // shift in ones so the line rests high after the stop bit
        frame_d = {1'b1, frame_q[NBITS-1:1]};
        if (bit_last) begin
          active_d = 1'b0;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end else begin
        baud_d = baud_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      frame_q  <= '1;
      baud_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
    end else begin
      frame_q  <= frame_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      active_q <= active_d;
    end
  end

  assign tx_o   = frame_q[0];
  assign done_o = active_q & baud_last & bit_last;

endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
//   Parses {HDR, SEL, 0x0D} frames from a byte-level UART receiver, updates
//   LED_select for SEL in '0'..'7', and answers "OK" or "ER" on tx. Bytes
//   arriving while a reply is being sent are dropped. A frame that stalls
//   for GAP_CYC cycles between bytes is abandoned without a reply.
//   Macro: UART_RESP_PARITY_EN adds even parity to each reply byte.
// Ports
//   iCLK        in   1  clock
//   RST         in   1  synchronous active-high reset
//   rx_data     in   8  received byte
//   rx_valid    in   1  one-cycle strobe per received byte
//   tx          out  1  serial reply, idle high
//   LED_select  out  3  last accepted select value
//   cmd_valid   out  1  one-cycle pulse per accepted frame (OK or ER)
//   busy        out  1  high while the reply is on the line
//   err_cnt     out  8  saturating count of ER replies
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int         CLK_HZ  = 50_000_000,
  parameter int         BAUD    = 9600,
  parameter logic [7:0] HDR     = HDR_DEFAULT,
  parameter int         GAP_CYC = 1_000_000
) (
  input  logic       iCLK,
  input  logic       RST,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       tx,
  output logic [2:0] LED_select,
  output logic       cmd_valid,
  output logic       busy,
  output logic [7:0] err_cnt
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int GAP_W        = $clog2(GAP_CYC + 1);

  state_e           state_q, state_d;
  logic [7:0]       sel_q, sel_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [2:0]       led_q, led_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             busy_q, busy_d;
  logic [7:0]       err_q, err_d;
  logic             byte_idx_q, byte_idx_d;   // 0: first reply byte on the line
  logic             reply_err_q, reply_err_d; // current reply is "ER"

  logic       tx_load;
  logic [7:0] tx_data;
  logic       tx_done;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    gap_d       = '0;
    led_d       = led_q;
    cmd_valid_d = 1'b0;
    busy_d      = busy_q;
    err_d       = err_q;
    byte_idx_d  = byte_idx_q;
    reply_err_d = reply_err_q;
    tx_load     = 1'b0;
    tx_data     = 8'h00;

    unique case (state_q)
      S_HDR: begin
        if (rx_valid && (rx_data == HDR)) state_d = S_SEL;
      end
      S_SEL: begin
        // any byte is taken as the select, even another header
        if (rx_valid) begin
          sel_d   = rx_data;
          state_d = S_END;
        end
      end
      S_END: begin
        if (rx_valid) begin
          if (rx_data == TERM) begin
            state_d     = S_REPLY;
            cmd_valid_d = 1'b1;
            busy_d      = 1'b1;
            byte_idx_d  = 1'b0;
            tx_load     = 1'b1;
            if (sel_in_range(sel_q)) begin
              led_d       = sel_q[2:0];
              reply_err_d = 1'b0;
              tx_data     = OK_B0;
            end else begin
              reply_err_d = 1'b1;
              tx_data     = ER_B0;
              if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end
          end else begin
            state_d = S_HDR;
          end
        end
      end
      S_REPLY: begin
        // rx_valid is ignored here: bytes during a reply are dropped
        if (tx_done) begin
          if (!byte_idx_q) begin
            byte_idx_d = 1'b1;
            tx_load    = 1'b1;
            tx_data    = reply_err_q ? ER_B1 : OK_B1;
          end else begin
            busy_d  = 1'b0;
            state_d = S_HDR;
          end
        end
      end
      default: state_d = S_HDR;
    endcase

    // Inter-byte gap watchdog, only while mid-frame
    if (((state_q == S_SEL) || (state_q == S_END)) && !rx_valid) begin
      if (gap_q == GAP_W'(GAP_CYC - 1)) begin
        state_d = S_HDR;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (RST) begin
      state_q     <= S_HDR;
      sel_q       <= 8'h00;
      gap_q       <= '0;
      led_q       <= 3'd0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 8'h00;
      byte_idx_q  <= 1'b0;
      reply_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      gap_q       <= gap_d;
      led_q       <= led_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      byte_idx_q  <= byte_idx_d;
      reply_err_q <= reply_err_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_i (iCLK),
    .srst_i(RST),
    .load_i(tx_load),
    .data_i(tx_data),
    .tx_o  (tx),
    .done_o(tx_done)
  );

  assign LED_select = led_q;
  assign cmd_valid  = cmd_valid_q;
  assign busy       = busy_q;
  assign err_cnt    = err_q;

endmodule
